spram_fifo_sched: RTL and testbench

// - Schedules one single-port SPRAM bank (16-bit words, registered read) as a streaming FIFO.
// - Owns all access to the bank: arbitrates write pushes against read prefetches, one access per cycle.
// - Presents valid/ready on both sides and hides RAM read latency behind a 2-entry output buffer.
// - Sits between the USB/SPI producers and consumers and the SPRAM primitive wrapper.

---
 rtl/spram_fifo_sched_pkg.sv | 20 ++
 rtl/spram_fifo_sched_if.sv | 36 +++
 rtl/spram_fifo_sched_obuf.sv | 49 ++++
 rtl/spram_fifo_sched.sv | 125 ++++++++++++
 tb/tb_spram_fifo_sched.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spram_fifo_sched_pkg.sv
// Shared definitions for the SPRAM FIFO scheduler: the per-cycle RAM operation
// encoding, the output-buffer depth and the width helper for the level counter.
package spram_sched_pkg;

   typedef enum logic [1:0] {
      OP_IDLE  = 2'd0,
      OP_WRITE = 2'd1,
      OP_READ  = 2'd2
   } op_e;

   // Words that can wait in front of the consumer once they have left the RAM
   localparam int OBUF_DEPTH = 2;

   // The level counter has to reach 2**addr_bits, so it needs one bit more
   // than the RAM address
   function automatic int level_width(input int addr_bits);
      return addr_bits + 1;
   endfunction

endpackage

// File: rtl/spram_fifo_sched_if.sv
// Stream and RAM-side bundle of the SPRAM FIFO scheduler.
// The slave modport is the scheduler's view; master is the view of the
// producer/consumer/RAM environment around it.
interface spram_fifo_sched_if #(
   parameter int ADDR_BITS  = 14,
   parameter int DATA_WIDTH = 16
);
   import spram_sched_pkg::*;

   localparam int LW = level_width(ADDR_BITS);

   logic                  flush;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [LW-1:0]         level;
   logic [ADDR_BITS-1:0]  ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic                  ram_we;
   logic                  ram_cs;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport slave (
      input  flush, wr_data, wr_valid, rd_ready, ram_rdata,
      output wr_ready, rd_data, rd_valid, level, ram_addr, ram_wdata, ram_we, ram_cs
   );

   modport master (
      output flush, wr_data, wr_valid, rd_ready, ram_rdata,
      input  wr_ready, rd_data, rd_valid, level, ram_addr, ram_wdata, ram_we, ram_cs
   );

endinterface

// File: rtl/spram_fifo_sched_obuf.sv
// Two-entry output skid FIFO that absorbs the RAM read latency. The head word
// drives rd_data directly; push and pop in the same cycle are both honoured.
module spram_sched_obuf
   import spram_sched_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [1:0]            cnt,
   output logic [DATA_WIDTH-1:0] head
);

   logic [DATA_WIDTH-1:0] mem [OBUF_DEPTH];
   logic                  wr_idx;
   logic                  rd_idx;

   // Entry storage and ring indices; clear drops contents without touching data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < OBUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_idx <= 1'b0;
         rd_idx <= 1'b0;
         cnt    <= 2'd0;
      end else if (clear) begin
         wr_idx <= 1'b0;
         rd_idx <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_idx] <= push_data;
            wr_idx      <= ~wr_idx;
         end
         if (pop) begin
            rd_idx <= ~rd_idx;
         end
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head = mem[rd_idx];

endmodule

// File: rtl/spram_fifo_sched.sv
// Streaming FIFO scheduler for one single-port SPRAM bank. Each cycle it
// issues at most one RAM access (write push or read prefetch) and hides the
// registered read latency behind a 2-entry output buffer.
// Optional build macro SPRAM_SCHED_RR_EN: contended write/read grants
// alternate round-robin instead of writes always winning.
module spram_fifo_sched
   import spram_sched_pkg::*;
#(
   parameter int ADDR_BITS  = 14,
   parameter int DATA_WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   spram_fifo_sched_if.slave  bus
);

   localparam int LW = level_width(ADDR_BITS);
   localparam logic [LW-1:0] CAP = {1'b1, {ADDR_BITS{1'b0}}};

   logic [ADDR_BITS-1:0]  wr_ptr;
   logic [ADDR_BITS-1:0]  rd_ptr;
   logic [LW-1:0]         stored;      // words still sitting in the RAM
   logic [LW-1:0]         level_q;     // RAM + in-flight + buffered words
   logic                  rd_inflight; // RAM data arrives this cycle
   logic                  active;      // keeps the RAM quiet until the first edge after reset
   logic [1:0]            buf_cnt;
   logic [DATA_WIDTH-1:0] buf_head;
   logic                  want_rd;
   logic                  want_wr;
   logic                  do_wr;
   logic                  do_rd;
   logic                  do_pop;
   op_e                   op;

`ifdef SPRAM_SCHED_RR_EN
   op_e                   last_grant;
`endif

   // Arbitration: an empty buffer always gets the read first so the consumer
   // is never starved; otherwise writes win (or alternate under round-robin)
   always_comb begin
      want_rd = (stored != '0) && ((int'(buf_cnt) + int'(rd_inflight)) < OBUF_DEPTH);
      want_wr = bus.wr_valid && (level_q != CAP);
      op      = OP_IDLE;
      if (active && !bus.flush) begin
         if (want_rd && (buf_cnt == 2'd0)) begin
            op = OP_READ;
`ifdef SPRAM_SCHED_RR_EN
         end else if (want_wr && want_rd) begin
            op = (last_grant == OP_READ) ? OP_WRITE : OP_READ;
`endif
         end else if (want_wr) begin
            op = OP_WRITE;
         end else if (want_rd) begin
            op = OP_READ;
         end
      end
   end

   assign do_wr  = (op == OP_WRITE);
   assign do_rd  = (op == OP_READ);
   assign do_pop = (buf_cnt != 2'd0) && bus.rd_ready && !bus.flush;

   assign bus.wr_ready  = do_wr;
   assign bus.ram_cs    = do_wr || do_rd;
   assign bus.ram_we    = do_wr;
   assign bus.ram_addr  = do_wr ? wr_ptr : rd_ptr;
   assign bus.ram_wdata = bus.wr_data;
   assign bus.rd_valid  = (buf_cnt != 2'd0);
   assign bus.rd_data   = buf_head;
   assign bus.level     = level_q;

   // Pointers, occupancy counters and the read-in-flight marker
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         stored      <= '0;
         level_q     <= '0;
         rd_inflight <= 1'b0;
         active      <= 1'b0;
      end else begin
         active <= 1'b1;
         if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            stored      <= '0;
            level_q     <= '0;
            rd_inflight <= 1'b0;
         end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            rd_inflight <= do_rd;
            stored      <= stored + LW'(do_wr) - LW'(do_rd);
            level_q     <= level_q + LW'(do_wr) - LW'(do_pop);
         end
      end
   end

`ifdef SPRAM_SCHED_RR_EN
   // Remembers the last granted access so contended grants alternate
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= OP_READ;
      end else if (op != OP_IDLE) begin
         last_grant <= op;
      end
   end
`endif

   // A word returning in the flush cycle is dropped by the buffer clear
   spram_sched_obuf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_obuf (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (bus.flush),
      .push      (rd_inflight),
      .push_data (bus.ram_rdata),
      .pop       (do_pop),
      .cnt       (buf_cnt),
      .head      (buf_head)
   );

endmodule

// File: tb/tb_spram_fifo_sched.sv
// Scoreboard bench for spram_fifo_sched at ADDR_BITS=4 with a behavioural
// registered-read RAM. Accepted pushes queue their word; the monitor pops and
// compares every word the DUT hands out.
module tb_spram_fifo_sched;
   import spram_sched_pkg::*;

   localparam int AB = 4;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   spram_fifo_sched_if #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) bus ();

   spram_fifo_sched #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Single-port RAM model with registered read
   logic [DW-1:0] ram [16];
   always @(posedge clk) begin
      if (bus.ram_cs) begin
         if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
         else            bus.ram_rdata     <= ram[bus.ram_addr];
      end
   end

   int n_checks = 0;
   int n_pass   = 0;
   logic [DW-1:0] exp_q [$];

   bit mon_gap_en = 1'b0;
   int gap = 0;
   int max_gap = 0;
   bit ops_en = 1'b0;
   int rd_ops = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   task automatic note_fail(input string name);
      n_checks++;
      $display("FAIL %s: got timeout/unexpected event, required normal completion", name);
   endtask

   // One clock of stimulus: drive at the falling edge, observe 1 time unit later
   task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic rr,
                              output logic acc);
      @(negedge clk);
      bus.wr_valid = v;
      bus.wr_data  = d;
      bus.rd_ready = rr;
      #1;
      acc = v && bus.wr_ready;
      if (acc) begin
         exp_q.push_back(d);
         $display("push %04h level=%0d", d, bus.level);
      end
   endtask

   task automatic drain(input string name);
      logic a;
      int t;
      t = 0;
      do begin
         drive_cycle(1'b0, '0, 1'b1, a);
         t++;
      end while (bus.level != '0 && t < 200);
      if (t >= 200) note_fail({name, "_drain_timeout"});
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: scoreboard compare, rd_valid gap tracking and read-op counting
   always begin
      @(negedge clk);
      #1;
      if (reset_n && bus.rd_valid && bus.rd_ready) begin
         if (exp_q.size() == 0) note_fail("unexpected_pop");
         else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            $display("pop  %04h expected %04h", bus.rd_data, e);
            check("rd_data", 32'(bus.rd_data), 32'(e));
         end
      end
      if (mon_gap_en) begin
         if (!bus.rd_valid && bus.level != '0) gap++;
         else gap = 0;
         if (gap > max_gap) max_gap = gap;
      end
      if (ops_en && bus.ram_cs && !bus.ram_we && bus.wr_valid && bus.level != 5'd16) rd_ops++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic a;
      int acc;
      logic [DW-1:0] nxt;

      bus.flush     = 1'b0;
      bus.wr_valid  = 1'b1;
      bus.wr_data   = 16'hFFFF;
      bus.rd_ready  = 1'b0;
      bus.ram_rdata = '0;

      // Reset state, with a push pending to show nothing leaks through
      repeat (3) @(negedge clk);
      #1;
      check("rst_level",    32'(bus.level),    32'd0);
      check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("rst_ram_cs",   32'(bus.ram_cs),   32'd0);
      check("rst_ram_we",   32'(bus.ram_we),   32'd0);
      check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
      check("rst_rd_data",  32'(bus.rd_data),  32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.wr_valid = 1'b0;
      drive_cycle(1'b0, '0, 1'b0, a);
      drive_cycle(1'b0, '0, 1'b0, a);

      // Single word: accepted at edge T, visible from T+2
      drive_cycle(1'b1, 16'hA55A, 1'b1, a);
      check("single_accept", 32'(a), 32'd1);
      drive_cycle(1'b0, '0, 1'b1, a);
      check("single_level_T",    32'(bus.level),    32'd1);
      check("single_valid_T",    32'(bus.rd_valid), 32'd0);
      drive_cycle(1'b0, '0, 1'b1, a);
      check("single_valid_T1",   32'(bus.rd_valid), 32'd0);
      drive_cycle(1'b0, '0, 1'b1, a);
      check("single_valid_T2",   32'(bus.rd_valid), 32'd1);
      check("single_level_T2",   32'(bus.level),    32'd1);
      drive_cycle(1'b0, '0, 1'b1, a);
      check("single_level_after", 32'(bus.level),   32'd0);
      check("single_valid_after", 32'(bus.rd_valid), 32'd0);

      // Fill with the consumer stalled, then drain the ramp
      rd_ops = 0;
      ops_en = 1'b1;
      acc = 0;
      for (int c = 0; c < 40; c++) begin
         drive_cycle(1'b1, 16'(acc), 1'b0, a);
         if (a) acc++;
      end
      ops_en = 1'b0;
      check("fill_count",    32'(acc),          32'd16);
      check("fill_level",    32'(bus.level),    32'd16);
      check("fill_wr_ready", 32'(bus.wr_ready), 32'd0);
`ifdef SPRAM_SCHED_RR_EN
      check("fill_read_ops", 32'(rd_ops), 32'd2);
`else
      check("fill_read_ops", 32'(rd_ops), 32'd1);
`endif
      drain("fill");

      // Contention: both sides saturated for 1000 words
      gap = 0;
      max_gap = 0;
      mon_gap_en = 1'b1;
      nxt = 16'h1000;
      acc = 0;
      for (int c = 0; c < 5000 && acc < 1000; c++) begin
         drive_cycle(1'b1, nxt, 1'b1, a);
         if (a) begin
            nxt++;
            acc++;
         end
      end
      drain("contention");
      mon_gap_en = 1'b0;
      check("contention_count", 32'(acc), 32'd1000);
      check("contention_gap_le2", 32'(max_gap <= 2), 32'd1);

      // Wrap: 3 x 16 words with an irregular consumer
      nxt = 16'h2000;
      acc = 0;
      for (int c = 0; c < 1000 && acc < 48; c++) begin
         drive_cycle(1'b1, nxt, 1'(c % 3 != 0), a);
         if (a) begin
            nxt++;
            acc++;
         end
      end
      check("wrap_count", 32'(acc), 32'd48);
      drain("wrap");

      // Flush with 5 words held and a read in flight
      acc = 0;
      for (int c = 0; c < 20 && acc < 5; c++) begin
         drive_cycle(1'b1, 16'(16'h3000 + acc), 1'b0, a);
         if (a) acc++;
      end
      check("flush_pushes", 32'(acc), 32'd5);
      drive_cycle(1'b0, '0, 1'b0, a);
`ifndef SPRAM_SCHED_RR_EN
      check("flush_pre_read", 32'({bus.ram_cs, bus.ram_we}), 32'd2);
`endif
      @(negedge clk);
      bus.flush = 1'b1;
      #1;
      check("flush_no_op",     32'(bus.ram_cs), 32'd0);
      check("flush_level_pre", 32'(bus.level),  32'd5);
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      check("flush_level",    32'(bus.level),    32'd0);
      check("flush_rd_valid", 32'(bus.rd_valid), 32'd0);
      exp_q.delete();
      drive_cycle(1'b1, 16'h0001, 1'b1, a);
      check("flush_push_accept", 32'(a), 32'd1);
      drain("flush");

      // Asynchronous reset in the middle of traffic
      for (int c = 0; c < 10; c++) begin
         drive_cycle(1'b1, 16'(16'h4000 + c), 1'b1, a);
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst_level",    32'(bus.level),    32'd0);
      check("midrst_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("midrst_ram_cs",   32'(bus.ram_cs),   32'd0);
      check("midrst_wr_ready", 32'(bus.wr_ready), 32'd0);
      exp_q.delete();
      bus.wr_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      drive_cycle(1'b0, '0, 1'b0, a);
      drive_cycle(1'b0, '0, 1'b0, a);
      drive_cycle(1'b1, 16'h1234, 1'b1, a);
      check("post_reset_accept", 32'(a), 32'd1);
      drain("post_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
